ram_bank_arbiter: RTL

- Two-requester round-robin arbiter and access sequencer for the 4x4x4-bit basic_ram bank.
- Accepts one request at a time over a valid/ready handshake and drives the bank's cs/we/oe/addr_row/addr_col/datain for exactly one strobe cycle.
- Returns read data, or a write acknowledge, to the granted requester.
- Sits between the CPU-side masters and basic_ram. It is the only driver of the bank's control pins.

---
 rtl/ram_bank_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ram_bank_arbiter.sv
// Round-robin arbiter and access sequencer for a two-requester 4x4 RAM bank.
// One request is accepted at a time; the bank gets a single registered strobe
// cycle, then the granted requester gets a one-cycle response pulse.
module ram_bank_arbiter #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ROW_W  = 2,
  parameter int unsigned COL_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ROW_W-1:0]  req0_row,
  input  logic [COL_W-1:0]  req0_col,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ROW_W-1:0]  req1_row,
  input  logic [COL_W-1:0]  req1_col,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              cs,
  output logic              we,
  output logic              oe,
  output logic [ROW_W-1:0]  addr_row,
  output logic [COL_W-1:0]  addr_col,
  output logic [DATA_W-1:0] datain,
  input  logic [DATA_W-1:0] dataout,
  output logic              busy
);

  typedef enum logic [2:0] {StIdle, StStrobe, StWrAck, StRdWait, StRdResp} state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                gnt_q, gnt_d;
  logic                op_we_q, op_we_d;
  logic                cs_q, cs_d, we_q, we_d, oe_q, oe_d;
  logic [ROW_W-1:0]    addr_row_q, addr_row_d;
  logic [COL_W-1:0]    addr_col_q, addr_col_d;
  logic [DATA_W-1:0]   datain_q, datain_d;
  logic                rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0]   rsp0_rdata_q, rsp0_rdata_d, rsp1_rdata_q, rsp1_rdata_d;
  logic                sel0, sel1, sel_we, idle;

  // Round-robin pick: a lone requester wins; on contention the one not last granted wins.
  always_comb begin
    idle       = (state_q == StIdle);
    sel0       = req0_valid && (!req1_valid || last_grant_q);
    sel1       = req1_valid && (!req0_valid || !last_grant_q);
    sel_we     = sel1 ? req1_we : req0_we;
    // rst_n gates ready so nothing can be accepted while reset is held
    req0_ready = idle && sel0 && rst_n;
    req1_ready = idle && sel1 && rst_n;
  end

  // Next-state and registered-output values; bank controls default to idle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    op_we_d      = op_we_q;
    cs_d         = 1'b0;
    we_d         = 1'b0;
    oe_d         = 1'b0;
    addr_row_d   = addr_row_q;
    addr_col_d   = addr_col_q;
    datain_d     = datain_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (sel0 || sel1) begin
          gnt_d        = sel1;
          last_grant_d = sel1;
          op_we_d      = sel_we;
          addr_row_d   = sel1 ? req1_row   : req0_row;
          addr_col_d   = sel1 ? req1_col   : req0_col;
          datain_d     = sel1 ? req1_wdata : req0_wdata;
          cs_d         = 1'b1;
          we_d         = sel_we;
          oe_d         = !sel_we;
          state_d      = StStrobe;
        end
      end
      StStrobe: begin
        if (op_we_q) begin
          state_d = StWrAck;
          if (gnt_q) begin
            rsp1_valid_d = 1'b1;
            rsp1_rdata_d = '0;
          end else begin
            rsp0_valid_d = 1'b1;
            rsp0_rdata_d = '0;
          end
        end else begin
          state_d = StRdWait;
        end
      end
      StWrAck: state_d = StIdle;
      StRdWait: begin
        // bank dataout is valid this cycle; capture it for the response pulse
        state_d = StRdResp;
        if (gnt_q) begin
          rsp1_valid_d = 1'b1;
          rsp1_rdata_d = dataout;
        end else begin
          rsp0_valid_d = 1'b1;
          rsp0_rdata_d = dataout;
        end
      end
      StRdResp: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      op_we_q      <= 1'b0;
      cs_q         <= 1'b0;
      we_q         <= 1'b0;
      oe_q         <= 1'b0;
      addr_row_q   <= '0;
      addr_col_q   <= '0;
      datain_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      op_we_q      <= op_we_d;
      cs_q         <= cs_d;
      we_q         <= we_d;
      oe_q         <= oe_d;
      addr_row_q   <= addr_row_d;
      addr_col_q   <= addr_col_d;
      datain_q     <= datain_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  // Drive ports straight from registers.
  always_comb begin
    cs         = cs_q;
    we         = we_q;
    oe         = oe_q;
    addr_row   = addr_row_q;
    addr_col   = addr_col_q;
    datain     = datain_q;
    rsp0_valid = rsp0_valid_q;
    rsp1_valid = rsp1_valid_q;
    rsp0_rdata = rsp0_rdata_q;
    rsp1_rdata = rsp1_rdata_q;
    busy       = (state_q != StIdle);
  end

endmodule
